// File: rtl/token_window_counter.sv
// Counts '1' tokens on a serial stream over fixed windows of WINDOW cycles and queues
// each window total in a small FWFT result FIFO with valid/ready output and sticky overflow.
module token_window_counter #(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(WINDOW + 1),
    parameter int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [LVL_W-1:0] level,
    output logic             ovf,
    input  logic             clear_ovf
);

    localparam int unsigned POS_W = $clog2(WINDOW);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [POS_W-1:0] pos;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             last;
    logic [CNT_W-1:0] result;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic             drop;
    logic [POS_W-1:0] pos_nxt;
    logic [CNT_W-1:0] acc_nxt;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [LVL_W-1:0] level_nxt;
    logic [CNT_W-1:0] head_nxt;

    // Window accumulation, FIFO bookkeeping and next head value.
    always_comb begin
        last       = (pos == POS_W'(WINDOW - 1));
        result     = acc + CNT_W'(a_in);
        pop        = out_valid & out_ready;
        full       = (level == LVL_W'(DEPTH));
        wr_en      = last & (~full | pop);
        drop       = last & full & ~pop;

        pos_nxt    = last ? '0 : pos + POS_W'(1);
        acc_nxt    = last ? '0 : result;
        wr_ptr_nxt = wr_en ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        level_nxt  = level + LVL_W'(wr_en) - LVL_W'(pop);

        // The slot being written can only become the head when the FIFO drains to it this edge.
        head_nxt = '0;
        if (level_nxt != '0) begin
            if (wr_en && (wr_ptr == rd_ptr_nxt)) begin
                head_nxt = result;
            end else begin
                head_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos       <= '0;
            acc       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            ovf       <= 1'b0;
        end else begin
            pos       <= pos_nxt;
            acc       <= acc_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            level     <= level_nxt;
            out_valid <= (level_nxt != '0);
            out_count <= head_nxt;
            // A drop on the same edge as clear_ovf keeps the flag set.
            if (drop) begin
                ovf <= 1'b1;
            end else if (clear_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    // Result storage needs no reset: contents are only visible through level.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= result;
        end
    end

endmodule

// File: tb/tb_token_window_counter.sv
// Directed bench for token_window_counter: the driver queues hand-computed window totals,
// a forked monitor compares the FIFO head against the queue on every falling edge.
module tb_token_window_counter;

    localparam int unsigned WINDOW = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned LVL_W  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_in;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic [LVL_W-1:0] level;
    logic             ovf;
    logic             clear_ovf;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    token_window_counter #(.WINDOW(WINDOW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .level     (level),
        .ovf       (ovf),
        .clear_ovf (clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives bits[n-1:0] MSB first; queues the expected total before the closing slot.
    task automatic drive_slots(input logic [15:0] bits, input int n, input bit push, input int exp);
        for (int i = n - 1; i >= 0; i--) begin
            a_in = bits[i];
            if (i == 0 && push) exp_q.push_back(exp);
            step();
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got count %0d, expected no result", out_count);
                end else begin
                    chk("sb_count", int'(out_count), exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_count", int'(out_count), 0);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        a_in      = 1'b0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        step();
        step();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_count", int'(out_count), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ovf", int'(ovf), 0);
        fork
            monitor();
        join_none
        rst = 1'b0;

        // Constant tokens: one-cycle pulse of 16 each window, level never above 1.
        out_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 16; i++) begin
                a_in = 1'b1;
                if (i == 15) exp_q.push_back(16);
                step();
                chk("t1_pulse", int'(out_valid), int'(i == 15));
                chk("t1_level_le1", int'(level <= 1), 1);
            end
        end

        // Sparse pattern then an all-zero window.
        drive_slots(16'b0100_0100_1000_0101, 16, 1'b1, 5);
        chk("t2_valid", int'(out_valid), 1);
        chk("t2_count", int'(out_count), 5);
        drive_slots(16'h0000, 16, 1'b1, 0);
        chk("t2_zero_valid", int'(out_valid), 1);
        chk("t2_zero_count", int'(out_count), 0);

        // Backpressure for five windows: fifth result is dropped.
        drive_slots(16'h0000, 1, 1'b0, 0);
        out_ready = 1'b0;
        drive_slots(16'h0001, 15, 1'b1, 1);
        drive_slots(16'h0003, 16, 1'b1, 2);
        drive_slots(16'h0007, 16, 1'b1, 3);
        drive_slots(16'h000F, 16, 1'b1, 4);
        drive_slots(16'h001F, 16, 1'b0, 0);
        chk("t3_level", int'(level), 4);
        chk("t3_ovf", int'(ovf), 1);
        chk("t3_head", int'(out_count), 1);
        out_ready = 1'b1;
        drive_slots(16'h0000, 4, 1'b0, 0);
        chk("t3_drained_level", int'(level), 0);
        chk("t3_drained_valid", int'(out_valid), 0);
        clear_ovf = 1'b1;
        drive_slots(16'h0000, 1, 1'b0, 0);
        clear_ovf = 1'b0;
        chk("t3_ovf_cleared", int'(ovf), 0);
        drive_slots(16'h0000, 11, 1'b1, 0);

        // Full FIFO with a pop exactly on the closing edge: no drop.
        drive_slots(16'h0001, 15, 1'b0, 0);
        out_ready = 1'b0;
        drive_slots(16'h0001, 1, 1'b1, 2);
        drive_slots(16'h0007, 16, 1'b1, 3);
        drive_slots(16'h000F, 16, 1'b1, 4);
        drive_slots(16'h001F, 16, 1'b1, 5);
        chk("t4_full_level", int'(level), 4);
        drive_slots(16'h003F, 15, 1'b0, 0);
        out_ready = 1'b1;
        drive_slots(16'h0000, 1, 1'b1, 6);
        out_ready = 1'b0;
        chk("t4_level", int'(level), 4);
        chk("t4_ovf", int'(ovf), 0);
        chk("t4_head", int'(out_count), 3);
        out_ready = 1'b1;
        drive_slots(16'h0000, 16, 1'b1, 0);

        // Mid-window reset with two results queued.
        drive_slots(16'h0001, 15, 1'b0, 0);
        out_ready = 1'b0;
        drive_slots(16'h0000, 1, 1'b1, 1);
        drive_slots(16'h0003, 16, 1'b1, 2);
        chk("t5_level", int'(level), 2);
        drive_slots(16'h007F, 7, 1'b0, 0);
        rst = 1'b1;
        step();
        exp_q.delete();
        chk("t5_rst_valid", int'(out_valid), 0);
        chk("t5_rst_count", int'(out_count), 0);
        chk("t5_rst_level", int'(level), 0);
        chk("t5_rst_ovf", int'(ovf), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        drive_slots(16'h0007, 16, 1'b1, 3);
        chk("t5_valid", int'(out_valid), 1);
        chk("t5_count", int'(out_count), 3);

        // Drop and clear_ovf on the same edge: set wins; later clear works.
        drive_slots(16'h0001, 15, 1'b0, 0);
        out_ready = 1'b0;
        drive_slots(16'h0000, 1, 1'b1, 1);
        drive_slots(16'h0001, 16, 1'b1, 1);
        drive_slots(16'h0001, 16, 1'b1, 1);
        drive_slots(16'h0001, 16, 1'b1, 1);
        drive_slots(16'h0000, 15, 1'b0, 0);
        clear_ovf = 1'b1;
        drive_slots(16'h0001, 1, 1'b0, 0);
        clear_ovf = 1'b0;
        chk("t6_ovf_set_wins", int'(ovf), 1);
        chk("t6_level", int'(level), 4);
        clear_ovf = 1'b1;
        drive_slots(16'h0000, 1, 1'b0, 0);
        clear_ovf = 1'b0;
        chk("t6_ovf_cleared", int'(ovf), 0);
        out_ready = 1'b1;
        drive_slots(16'h0000, 15, 1'b1, 0);

        // Bounded drain of whatever the scoreboard still expects.
        a_in = 1'b0;
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) step();
        chk("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
